// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage between the PC register and the IF/ID boundary.
//
// Issues a synchronous instruction-memory read for pc_in every cycle the pipeline
// advances. It delivers {pc, instruction, valid} to IF/ID one cycle after the read
// returns. A one-entry hold buffer catches a read that is already in flight when a
// stall arrives, so that read is never lost. A flush squashes every wrong-path fetch.
//
// Ports:
//   CLK          in   system clock, all state on posedge
//   Reset        in   synchronous active-high reset
//   pc_in        in   current PC from the PC register
//   stall        in   hazard stall: hold IF/ID and PC
//   flush        in   branch/jump taken: squash wrong-path fetches
//   imem_addr    out  instruction-memory address (equals pc_in)
//   imem_req     out  read strobe; data returns on imem_rdata next cycle
//   imem_rdata   in   read data for the previous cycle's request
//   pc_write     out  PC register load enable
//   pc_plus4     out  pc_in + 4 (wraps modulo 2^32)
//   id_valid     out  IF/ID holds a real instruction
//   id_pc        out  PC of the IF/ID instruction
//   id_instr     out  IF/ID instruction word
//   instr_count  out  number of valid instructions loaded into IF/ID
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic        pc_write,
    output logic [31:0] pc_plus4,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] instr_count
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] cnt_q, cnt_d;

    assign imem_addr   = pc_in;
    assign imem_req    = !Reset && !stall && !flush;
    // A flush must load the branch target even while the hazard unit stalls.
    assign pc_write    = !Reset && (flush || !stall);
    assign pc_plus4    = pc_in + 32'd4;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign instr_count = cnt_q;

    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        cnt_d        = cnt_q;
        if (flush) begin
            id_valid_d  = 1'b0;
            id_pc_d     = RESET_PC;
            id_instr_d  = NOP_INSTR;
            req_valid_d = 1'b0;
            state_d     = RUN;
        end else if (state_q == RUN) begin
            if (!stall) begin
                id_valid_d  = req_valid_q;
                id_pc_d     = req_pc_q;
                id_instr_d  = imem_rdata;
                req_valid_d = 1'b1;
                req_pc_d    = pc_in;
                cnt_d       = cnt_q + {31'b0, req_valid_q};
            end else begin
                // The read data returning now would be lost next cycle, so park it.
                if (req_valid_q) begin
                    hold_pc_d    = req_pc_q;
                    hold_instr_d = imem_rdata;
                    state_d      = HOLD;
                end
                req_valid_d = 1'b0;
            end
        end else if (!stall) begin
            id_valid_d  = 1'b1;
            id_pc_d     = hold_pc_q;
            id_instr_d  = hold_instr_q;
            req_valid_d = 1'b1;
            req_pc_d    = pc_in;
            state_d     = RUN;
            cnt_d       = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= RUN;
            req_valid_q  <= 1'b0;
            req_pc_q     <= RESET_PC;
            hold_pc_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            id_valid_q   <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_instr_q   <= NOP_INSTR;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule
